// File: rtl/i2c_line_filter.sv
// I2C SCL/SDA input conditioning: 2-flop synchronizer, per-line glitch filter,
// and registered decode of SCL edges, START/STOP and bus-busy.
module i2c_line_filter #(
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned WIDTH_FILT  = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl_raw,
  input  logic i_sda_raw,
  output logic o_scl,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_busy,
  output logic o_glitch
);

  localparam logic [WIDTH_FILT-1:0] CNT_LAST = WIDTH_FILT'(FILT_CYCLES - 1);

  logic                  r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic [WIDTH_FILT-1:0] r_scl_cnt, r_sda_cnt;
  logic                  r_scl, r_sda, r_scl_d, r_sda_d;
  logic                  r_scl_rise, r_scl_fall, r_start, r_stop, r_busy, r_glitch;
  logic                  w_scl_glitch, w_sda_glitch;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= i_scl_raw;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= i_sda_raw;
      r_sda_s2 <= r_sda_s1;
    end
  end

  // A pending transition is abandoned when the line returns before the count completes.
  assign w_scl_glitch = (r_scl_s2 == r_scl) && (r_scl_cnt != '0);
  assign w_sda_glitch = (r_sda_s2 == r_sda) && (r_sda_cnt != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl     <= 1'b1;
      r_scl_cnt <= '0;
    end else if (r_scl_s2 == r_scl) begin
      r_scl_cnt <= '0;
    end else if (r_scl_cnt == CNT_LAST) begin
      r_scl     <= r_scl_s2;
      r_scl_cnt <= '0;
    end else begin
      r_scl_cnt <= r_scl_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sda     <= 1'b1;
      r_sda_cnt <= '0;
    end else if (r_sda_s2 == r_sda) begin
      r_sda_cnt <= '0;
    end else if (r_sda_cnt == CNT_LAST) begin
      r_sda     <= r_sda_s2;
      r_sda_cnt <= '0;
    end else begin
      r_sda_cnt <= r_sda_cnt + 1'b1;
    end
  end

  // START/STOP require SCL high in both samples, so a simultaneous SCL+SDA change yields only an SCL edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
      r_glitch   <= 1'b0;
    end else begin
      r_scl_d    <= r_scl;
      r_sda_d    <= r_sda;
      r_scl_rise <= ~r_scl_d & r_scl;
      r_scl_fall <= r_scl_d & ~r_scl;
      r_start    <= r_scl_d & r_scl & r_sda_d & ~r_sda;
      r_stop     <= r_scl_d & r_scl & ~r_sda_d & r_sda;
      r_glitch   <= w_scl_glitch | w_sda_glitch;
      if (r_start) begin
        r_busy <= 1'b1;
      end else if (r_stop) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_scl      = r_scl;
  assign o_sda      = r_sda;
  assign o_scl_rise = r_scl_rise;
  assign o_scl_fall = r_scl_fall;
  assign o_start    = r_start;
  assign o_stop     = r_stop;
  assign o_busy     = r_busy;
  assign o_glitch   = r_glitch;

endmodule

// File: tb/tb_i2c_line_filter.sv
// Self-checking bench for i2c_line_filter: cycle scoreboard against a behavioural
// model plus directed latency/event-count checks.
module tb_i2c_line_filter;

  localparam int unsigned FILT = 4;
  localparam int unsigned WF   = 3;
  localparam int unsigned HALF = 62;  // ~5 us at 80 ns

  logic clk = 1'b0;
  logic rst, scl_raw, sda_raw;
  logic o_scl, o_sda, o_scl_rise, o_scl_fall, o_start, o_stop, o_busy, o_glitch;

  always #40 clk = ~clk;

  i2c_line_filter #(.FILT_CYCLES(FILT), .WIDTH_FILT(WF)) dut (
    .i_clk(clk), .i_rst(rst), .i_scl_raw(scl_raw), .i_sda_raw(sda_raw),
    .o_scl(o_scl), .o_sda(o_sda), .o_scl_rise(o_scl_rise), .o_scl_fall(o_scl_fall),
    .o_start(o_start), .o_stop(o_stop), .o_busy(o_busy), .o_glitch(o_glitch)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic scl, sda, rise, fall, start, stop, busy, glitch;
  } obs_t;

  obs_t exp_q[$];

  // Behavioural model: each line follows its synchronized level only after
  // FILT consecutive disagreeing samples.
  logic        m_scl_s1, m_scl_s2, m_sda_s1, m_sda_s2, m_scl_d, m_sda_d;
  int unsigned m_scl_run, m_sda_run;
  obs_t        m_o;

  always @(posedge clk) begin : model
    obs_t n;
    n = '0;
    if (rst) begin
      m_scl_s1 = 1'b1; m_scl_s2 = 1'b1; m_sda_s1 = 1'b1; m_sda_s2 = 1'b1;
      m_scl_d = 1'b1; m_sda_d = 1'b1;
      m_scl_run = 0; m_sda_run = 0;
      n.scl = 1'b1; n.sda = 1'b1;
    end else begin
      n.rise   = ~m_scl_d & m_o.scl;
      n.fall   = m_scl_d & ~m_o.scl;
      n.start  = m_scl_d & m_o.scl & m_sda_d & ~m_o.sda;
      n.stop   = m_scl_d & m_o.scl & ~m_sda_d & m_o.sda;
      n.busy   = m_o.start ? 1'b1 : (m_o.stop ? 1'b0 : m_o.busy);
      n.glitch = (m_scl_s2 == m_o.scl && m_scl_run != 0) ||
                 (m_sda_s2 == m_o.sda && m_sda_run != 0);
      m_scl_d = m_o.scl;
      m_sda_d = m_o.sda;
      n.scl = m_o.scl;
      if (m_scl_s2 != m_o.scl) begin
        if (m_scl_run + 1 == FILT) begin n.scl = m_scl_s2; m_scl_run = 0; end
        else m_scl_run++;
      end else m_scl_run = 0;
      n.sda = m_o.sda;
      if (m_sda_s2 != m_o.sda) begin
        if (m_sda_run + 1 == FILT) begin n.sda = m_sda_s2; m_sda_run = 0; end
        else m_sda_run++;
      end else m_sda_run = 0;
      m_scl_s2 = m_scl_s1; m_scl_s1 = scl_raw;
      m_sda_s2 = m_sda_s1; m_sda_s1 = sda_raw;
    end
    m_o = n;
    exp_q.push_back(n);
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_glitch = 0;
  int unsigned n_scl_low = 0, n_sda_low = 0;
  int unsigned sda_fall_cyc = 0, start_cyc = 0, stop_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
  logic prev_sda = 1'b1, prev_busy = 1'b0;

  always @(negedge clk) begin : monitor
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", 32'({o_scl, o_sda, o_scl_rise, o_scl_fall, o_start, o_stop, o_busy, o_glitch}),
            32'(e));
    end
    if (o_scl_rise) n_rise++;
    if (o_scl_fall) n_fall++;
    if (o_start) begin n_start++; start_cyc = cyc; end
    if (o_stop) begin n_stop++; stop_cyc = cyc; end
    if (o_glitch) n_glitch++;
    if (!o_scl) n_scl_low++;
    if (!o_sda) n_sda_low++;
    if (prev_sda && !o_sda) sda_fall_cyc = cyc;
    if (!prev_busy && o_busy) busy_rise_cyc = cyc;
    if (prev_busy && !o_busy) busy_fall_cyc = cyc;
    prev_sda  = o_sda;
    prev_busy = o_busy;
  end

  int unsigned s_rise, s_fall, s_start, s_stop, s_glitch, s_scl_low, s_sda_low, base, t_start1;

  task automatic snap();
    s_rise = n_rise; s_fall = n_fall; s_start = n_start; s_stop = n_stop;
    s_glitch = n_glitch; s_scl_low = n_scl_low; s_sda_low = n_sda_low;
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; scl_raw = 1'b1; sda_raw = 1'b1;
    wait_cyc(2);
    check("rst_lines", {o_scl, o_sda}, 2'b11);
    check("rst_pulses", {o_scl_rise, o_scl_fall, o_start, o_stop, o_glitch}, 5'b0);
    check("rst_busy", o_busy, 1'b0);
    rst = 1'b0;

    // Idle bus stays quiet
    snap();
    wait_cyc(100);
    check("idle_events", (n_rise + n_fall + n_start + n_stop + n_glitch) -
                         (s_rise + s_fall + s_start + s_stop + s_glitch), 0);
    check("idle_low", (n_scl_low + n_sda_low) - (s_scl_low + s_sda_low), 0);

    // 3-cycle SDA glitch is rejected
    snap();
    sda_raw = 1'b0; wait_cyc(3); sda_raw = 1'b1;
    wait_cyc(15);
    check("g3_sda_low", n_sda_low - s_sda_low, 0);
    check("g3_start", n_start - s_start, 0);
    check("g3_glitch", n_glitch - s_glitch, 1);

    // 4-cycle SDA pulse passes: START then STOP
    snap(); base = cyc;
    sda_raw = 1'b0; wait_cyc(4); sda_raw = 1'b1;
    wait_cyc(24);
    check("p4_fall_edge", sda_fall_cyc - base, 6);
    check("p4_start_edge", start_cyc - base, 7);
    check("p4_start_cnt", n_start - s_start, 1);
    check("p4_stop_cnt", n_stop - s_stop, 1);
    check("p4_glitch", n_glitch - s_glitch, 0);
    check("p4_busy", o_busy, 1'b0);

    // Transaction: START, 9 clocks, repeated START, STOP
    snap(); base = cyc;
    sda_raw = 1'b0; wait_cyc(HALF);
    t_start1 = start_cyc;
    check("tx_start_edge", t_start1 - base, 7);
    check("tx_busy_rise", busy_rise_cyc - t_start1, 1);
    scl_raw = 1'b0; wait_cyc(HALF / 2);
    for (int i = 0; i < 9; i++) begin
      sda_raw = 1'($urandom_range(0, 1));
      wait_cyc(HALF / 2);
      scl_raw = 1'b1; wait_cyc(HALF);
      scl_raw = 1'b0; wait_cyc(HALF / 2);
    end
    sda_raw = 1'b1; wait_cyc(HALF / 2);
    scl_raw = 1'b1; wait_cyc(HALF);
    sda_raw = 1'b0; wait_cyc(HALF);
    scl_raw = 1'b0; wait_cyc(HALF);
    scl_raw = 1'b1; wait_cyc(HALF);
    sda_raw = 1'b1; wait_cyc(HALF);
    check("tx_rise", n_rise - s_rise, 11);
    check("tx_fall", n_fall - s_fall, 11);
    check("tx_start", n_start - s_start, 2);
    check("tx_stop", n_stop - s_stop, 1);
    check("tx_busy_fall", busy_fall_cyc - stop_cyc, 1);
    check("tx_busy_end", o_busy, 1'b0);

    // SDA toggling while SCL is low is not START/STOP
    sda_raw = 1'b0; wait_cyc(20);
    scl_raw = 1'b0; wait_cyc(20);
    snap();
    sda_raw = 1'b1; wait_cyc(20);
    sda_raw = 1'b0; wait_cyc(20);
    check("sl_start", n_start - s_start, 0);
    check("sl_stop", n_stop - s_stop, 0);
    check("sl_busy", o_busy, 1'b1);
    scl_raw = 1'b1; wait_cyc(20);
    sda_raw = 1'b1; wait_cyc(20);
    check("sl_stop_end", n_stop - s_stop, 1);

    // Simultaneous SCL/SDA changes give only SCL edges
    snap();
    scl_raw = 1'b0; sda_raw = 1'b0; wait_cyc(20);
    check("sim_fall", n_fall - s_fall, 1);
    check("sim_dn_ss", (n_start - s_start) + (n_stop - s_stop), 0);
    snap();
    scl_raw = 1'b1; sda_raw = 1'b1; wait_cyc(20);
    check("sim_rise", n_rise - s_rise, 1);
    check("sim_up_ss", (n_start - s_start) + (n_stop - s_stop), 0);
    check("sim_busy", o_busy, 1'b0);

    // Reset while busy with SDA held low
    sda_raw = 1'b0; wait_cyc(20);
    check("rm_busy_pre", o_busy, 1'b1);
    rst = 1'b1; wait_cyc(1);
    check("rm_busy", o_busy, 1'b0);
    check("rm_lines", {o_scl, o_sda}, 2'b11);
    rst = 1'b0; base = cyc; snap();
    wait_cyc(20);
    check("rm_fall_edge", sda_fall_cyc - base, 6);
    check("rm_start_edge", start_cyc - base, 7);
    check("rm_start_cnt", n_start - s_start, 1);
    sda_raw = 1'b1; wait_cyc(20);
    check("rm_busy_end", o_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
